// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB low-level transmit encoder.
// USB_TX_SYNC_EN adds the SYNC state to the state enum.
package usb_tx_pkg;

    localparam logic [7:0]  SYNC_BYTE    = 8'h80;
    localparam int unsigned STUFF_LIMIT  = 6;
    localparam int unsigned EOP_SE0_BITS = 2;
    localparam int unsigned ONES_W       = 3;
    localparam int unsigned BIT_IDX_W    = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        STUFF   = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
`ifdef USB_TX_SYNC_EN
        ,
        SYNC    = 3'd5
`endif
    } tx_state_e;

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period counter: free-runs while enabled, strobes on the last clock of each bit period.
module usb_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_strobe_c
);

    localparam int unsigned    CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Held at zero while disabled so the first period after a start is full length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_strobe_c = en && (cnt == CNT_MAX);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB transmit encoder: byte handshake, NRZI with bit stuffing, EOP generation.
// Define USB_TX_SYNC_EN to prefix each packet with the SYNC byte.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_active,
    output logic       tx_err
);

    tx_state_e            state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic                 last_q, last_d;
    logic [ONES_W-1:0]    ones_q, ones_d, ones_nx;
    logic                 line_q, line_d;
    logic [7:0]           hold_data_q, hold_data_d;
    logic                 hold_last_q, hold_last_d;
    logic                 hold_full_q, hold_full_d;
    logic                 dp_d, dm_d, ready_d, active_d, err_d;

    logic       bit_strobe_c;
    logic       xfer_c;
    logic       advance, emit_en, emit_bit, load_en, load_last;
    logic [7:0] load_data;

    assign xfer_c = tx_valid && tx_ready;

    usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk          (clk),
        .rst          (rst),
        .en           (state_q != IDLE),
        .bit_strobe_c (bit_strobe_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            last_q      <= 1'b0;
            ones_q      <= '0;
            line_q      <= 1'b1;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            d_plus      <= 1'b1;
            d_minus     <= 1'b0;
            tx_ready    <= 1'b1;
            tx_active   <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            last_q      <= last_d;
            ones_q      <= ones_d;
            line_q      <= line_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            d_plus      <= dp_d;
            d_minus     <= dm_d;
            tx_ready    <= ready_d;
            tx_active   <= active_d;
            tx_err      <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        last_d      = last_q;
        ones_d      = ones_q;
        line_d      = line_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        dp_d        = d_plus;
        dm_d        = d_minus;
        err_d       = 1'b0;
        advance     = 1'b0;
        emit_en     = 1'b0;
        emit_bit    = 1'b0;
        load_en     = 1'b0;
        load_data   = hold_data_q;
        load_last   = hold_last_q;
        ones_nx     = shift_q[0] ? ones_q + ONES_W'(1) : '0;

        if (xfer_c) begin
            hold_data_d = tx_data;
            hold_last_d = tx_last;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                dp_d   = 1'b1;
                dm_d   = 1'b0;
                line_d = 1'b1;
                ones_d = '0;
`ifdef USB_TX_SYNC_EN
                // The accepted byte waits in the holding register behind SYNC.
                if (hold_full_q || xfer_c) begin
                    state_d   = SYNC;
                    shift_d   = SYNC_BYTE;
                    last_d    = 1'b0;
                    bit_idx_d = '0;
                    emit_en   = 1'b1;
                    emit_bit  = SYNC_BYTE[0];
                end
`else
                if (hold_full_q) begin
                    load_en = 1'b1;
                end else if (xfer_c) begin
                    load_en   = 1'b1;
                    load_data = tx_data;
                    load_last = tx_last;
                end
`endif
            end
`ifdef USB_TX_SYNC_EN
            SYNC,
`endif
            DATA: begin
                if (bit_strobe_c) begin
                    if (ones_nx == ONES_W'(STUFF_LIMIT)) begin
                        state_d  = STUFF;
                        ones_d   = '0;
                        emit_en  = 1'b1;
                        emit_bit = 1'b0;
                    end else begin
                        ones_d  = ones_nx;
                        advance = 1'b1;
                    end
                end
            end
            STUFF: begin
                if (bit_strobe_c) begin
                    advance = 1'b1;
                end
            end
            EOP_SE0: begin
                if (bit_strobe_c) begin
                    if (bit_idx_q == BIT_IDX_W'(EOP_SE0_BITS - 1)) begin
                        state_d = EOP_J;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
                        line_d  = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
            EOP_J: begin
                if (bit_strobe_c) begin
                    state_d = IDLE;
                    ones_d  = '0;
                    line_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Move to the next data bit, or finish the byte.
        if (advance) begin
            if (bit_idx_q != BIT_IDX_W'(7)) begin
                shift_d   = shift_q >> 1;
                bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                emit_en   = 1'b1;
                emit_bit  = shift_q[1];
                if (state_q == STUFF) begin
                    state_d = DATA;
                end
            end else if (!last_q && hold_full_q) begin
                load_en = 1'b1;
            end else begin
                err_d     = !last_q;
                state_d   = EOP_SE0;
                bit_idx_d = '0;
                dp_d      = 1'b0;
                dm_d      = 1'b0;
            end
        end

        if (load_en) begin
            state_d     = DATA;
            shift_d     = load_data;
            last_d      = load_last;
            bit_idx_d   = '0;
            hold_full_d = 1'b0;
            emit_en     = 1'b1;
            emit_bit    = load_data[0];
        end

        // NRZI: a 0 toggles the line, a 1 holds it.
        if (emit_en) begin
            line_d = emit_bit ? line_q : ~line_q;
            dp_d   = line_d;
            dm_d   = ~line_d;
        end

        active_d = (state_d != IDLE);
        ready_d  = !hold_full_d && (state_d != EOP_SE0) && (state_d != EOP_J);
    end

endmodule

// File: doc/usb_tx_encoder.md
USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 4, clk cycles per USB bit period (legal values 2..15).
REQ-002 SHALL have port: clk  input  1  single rising-edge clock.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: tx_data  input  8  packet byte, sent LSB first.
REQ-005 SHALL have port: tx_valid  input  1  tx_data is valid.
REQ-006 SHALL have port: tx_last  input  1  qualifies tx_data as the final byte of the packet.
REQ-007 SHALL have port: tx_ready  output  1  holding register can accept a byte.
REQ-008 SHALL have port: d_plus  output  1  D+ line.
REQ-009 SHALL have port: d_minus  output  1  D- line.
REQ-010 SHALL have port: tx_active  output  1  packet in progress, including EOP.
REQ-011 SHALL have port: tx_err  output  1  one-cycle pulse on underrun.

Function
REQ-012 SHALL transfer a byte only in a cycle where tx_valid && tx_ready; tx_data and tx_last are captured into a one-byte holding register.
REQ-013 SHALL drive tx_ready high when the holding register is empty and the state is neither EOP_SE0 nor EOP_J.
REQ-014 SHALL implement the states IDLE, DATA, STUFF, EOP_SE0 and EOP_J, plus SYNC when configured.
REQ-015 IDLE: SHALL drive J (d_plus=1, d_minus=0) with tx_active=0; a transfer moves the byte to the shift register, and the first bit period starts on the next cycle.
REQ-016 SHALL hold each line bit for exactly CLKS_PER_BIT cycles; all transitions SHALL align to bit-period boundaries.
REQ-017 NRZI: a 0 bit SHALL toggle the line (d_plus and d_minus complement each other), and a 1 bit SHALL hold the line.
REQ-018 SHALL count consecutive 1s across byte boundaries; after the 6th consecutive 1 it SHALL insert one stuffed 0 bit period (STUFF state), then reset the count; any 0 SHALL also reset the count.
REQ-019 At the last bit boundary of a byte, if the holding register is full, SHALL load it with no idle gap.
REQ-020 After a byte marked tx_last (and any stuff bit it triggers), SHALL go to EOP_SE0: d_plus=0, d_minus=0 for 2 bit periods.
REQ-021 EOP_J: SHALL drive J for 1 bit period, then go to IDLE with the NRZI previous-level register at J and the ones count cleared.
REQ-022 Underrun: if a non-last byte completes while the holding register is empty, SHALL pulse tx_err for 1 cycle and enter EOP_SE0.
REQ-023 SHALL ignore tx_valid during EOP_SE0 and EOP_J, because tx_ready is low in those states.

Reset
REQ-024 On rst, SHALL asynchronously go to IDLE: d_plus=1, d_minus=0, tx_ready=1, tx_active=0, tx_err=0, holding register empty, ones count 0, bit timer 0.
REQ-025 If rst occurs mid-packet, SHALL abandon the packet without emitting an EOP.

Configuration
REQ-026 With USB_TX_SYNC_EN defined, SHALL emit SYNC byte 8'h80 (LSB first, stuffing applied) in a SYNC state before the first accepted byte.
REQ-027 Without USB_TX_SYNC_EN, the first accepted byte SHALL be the first bits on the line, and the SYNC state and logic SHALL be absent.

Structure
REQ-028 Package usb_tx_pkg SHALL hold: state enum, SYNC_BYTE=8'h80, STUFF_LIMIT=6, EOP_SE0_BITS=2.
REQ-029 Sub-module usb_bit_timer SHALL implement the CLKS_PER_BIT counter and issue a one-cycle bit_strobe at each bit-period end.

Verification
REQ-030 Test A (CLKS_PER_BIT=4, no SYNC): send 8'h00 with tx_last -> d_plus toggles every 4 cycles starting 1->0 for 8 periods, then SE0 for 8 cycles, J for 4 cycles, tx_active falls.
REQ-031 Test B: send 8'hFF with tx_last -> line holds 6 periods, toggles once for the stuff bit, holds 2 periods, then EOP (9 bit periods before EOP).
REQ-032 Test C: send 8'h3C then 8'hA5 (second with tx_last), tx_valid held -> continuous 16-bit NRZI stream with no gap; tx_ready re-asserts after 8'h3C moves to the shift register.
REQ-033 Test D: send 8'h12 without tx_last, then tx_valid=0 -> tx_err pulses 1 cycle after bit 8, then a normal EOP.
REQ-034 Test E: assert rst during bit 3 of 8'h55 -> same cycle d_plus=1, d_minus=0, tx_active=0; after release, tx_ready=1.
REQ-035 Test F (USB_TX_SYNC_EN): send 8'h00 with tx_last -> first 8 periods are KJKJKJKK, followed by 8 toggling periods, then EOP.
